// File: rtl/id_inst_buffer_pkg.sv
// Shared types for the IF->ID instruction buffer.
// Holds the default depth and the head-source encoding.
package id_inst_buffer_pkg;

  localparam int ID_BUF_DEPTH = 4;

  typedef enum logic [1:0] {
    HEAD_NONE,
    HEAD_QUEUE,
    HEAD_BYPASS
  } head_src_e;

endpackage

// File: rtl/id_buf_ram.sv
// DEPTH x WIDTH register array, one write port, one async read port.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side. No data reset.
module id_buf_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_inst_buffer.sv
// In-order IF->ID instruction queue with zero-bubble bypass, fetch credit
// and branch flush. Ports: clk/rst, IF side (if_valid, if_pc,
// inst_sram_rdata, fetch_allow), ID side (id_stall, flush, id_valid,
// id_pc, id_inst), count of queued entries.
module id_inst_buffer
  import id_inst_buffer_pkg::*;
#(
  parameter int DEPTH      = ID_BUF_DEPTH,
  parameter int PC_W       = 32,
  parameter int INST_W     = 32,
  parameter int DELAY_SLOT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INST_W-1:0]          inst_sram_rdata,
  output logic                       fetch_allow,
  input  logic                       id_stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + INST_W;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [AW-1:0]   rd_ptr, wr_ptr, rd_nx, wr_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            infl_v, infl_v_nx;
  logic [PC_W-1:0] infl_pc;
  logic [EW-1:0]   q_head;
  logic [CW:0]     occ;
  head_src_e       src;
  logic            consume, fire, do_flush;
  logic            deq, enq, we;

  id_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (we & ~rst),
    .waddr (wr_ptr),
    .wdata ({infl_pc, inst_sram_rdata}),
    .raddr (rd_ptr),
    .rdata (q_head)
  );

  // Credit counts the in-flight response so it always has a slot.
  assign occ = {1'b0, cnt} + {{CW{1'b0}}, infl_v};
  assign fetch_allow = occ < DEPTH_C;

  always_comb begin
    src = HEAD_NONE;
    if (cnt != '0)  src = HEAD_QUEUE;
    else if (infl_v) src = HEAD_BYPASS;
  end

  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    case (src)
      HEAD_QUEUE: begin
        id_valid = 1'b1;
        id_pc    = q_head[EW-1:INST_W];
        id_inst  = q_head[INST_W-1:0];
      end
      HEAD_BYPASS: begin
        id_valid = 1'b1;
        id_pc    = infl_pc;
        id_inst  = inst_sram_rdata;
      end
      default: ;
    endcase
  end

  assign consume  = id_valid & ~id_stall;
  assign fire     = if_valid & fetch_allow;
  assign do_flush = flush & consume;
  assign deq      = consume & (src == HEAD_QUEUE);
  assign enq      = infl_v & ~(consume & (src == HEAD_BYPASS));

  always_comb begin
    rd_nx     = rd_ptr + AW'(deq);
    wr_nx     = wr_ptr + AW'(enq);
    cnt_nx    = cnt + CW'(enq) - CW'(deq);
    infl_v_nx = fire;
    we        = enq;
    if (do_flush) begin
      if (DELAY_SLOT == 0) begin
        we        = 1'b0;
        rd_nx     = wr_ptr;
        wr_nx     = wr_ptr;
        cnt_nx    = '0;
        infl_v_nx = 1'b0;
      end else if (src == HEAD_QUEUE) begin
        if (cnt > CW'(1)) begin
          // Delay slot already queued: keep exactly that entry.
          we        = 1'b0;
          wr_nx     = rd_ptr + AW'(2);
          cnt_nx    = CW'(1);
          infl_v_nx = 1'b0;
        end else begin
          // Delay slot is the in-flight response if any, else the new fetch.
          infl_v_nx = fire & ~infl_v;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      infl_v  <= 1'b0;
      infl_pc <= '0;
    end else begin
      rd_ptr  <= rd_nx;
      wr_ptr  <= wr_nx;
      cnt     <= cnt_nx;
      infl_v  <= infl_v_nx;
      infl_pc <= if_pc;
    end
  end

  assign count = cnt;

endmodule
